// File: rtl/sum_scheduler_pkg.sv
// Shared types and helpers for the bit-serial adder scheduler.
package sum_scheduler_pkg;

    // Operation requested by a client; encodes which adder operand is negated.
    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_SUB_AB = 2'd1,
        OP_SUB_BA = 2'd2,
        OP_NEG    = 2'd3
    } op_t;

    // Frame FSM: whether the frame currently serializing carries a granted op.
    typedef enum logic {
        IDLE_FRAME = 1'b0,
        OP_FRAME   = 1'b1
    } frame_state_t;

    // Map an op to the adder's {minus_a, minus_b} controls.
    function automatic logic [1:0] op_to_minus(input op_t op);
        logic [1:0] m;
        case (op)
            OP_ADD:    m = 2'b00;
            OP_SUB_AB: m = 2'b01;
            OP_SUB_BA: m = 2'b10;
            default:   m = 2'b11;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sum_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered
// pointer; the pointer moves past the winner only when advance_i is strobed.
module rr_arbiter
    import sum_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic          found;

    // Search requests starting at the pointer, wrapping modulo N.
    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        grant_o     = '0;
        cand        = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(off);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[IW-1:0];
            end
        end
        if (found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
        any_o = found;
    end

    // Next pointer: one past the winner on an accepted advance.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sum_scheduler.sv
// Sequencer for the shared bit-serial adder: produces bclk/lrclk framing,
// grants one adder frame per accepted request, serializes operands MSB first
// and returns the adder's parallel result to the requester one frame later.
module sum_scheduler
    import sum_scheduler_pkg::*;
#(
    parameter int W          = 32,
    parameter int N_REQ      = 4,
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [W*N_REQ-1:0]       req_a,
    input  logic [W*N_REQ-1:0]       req_b,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     ser_a,
    output logic                     ser_b,
    output logic                     minus_a,
    output logic                     minus_b,
    input  logic [W-1:0]             sum_p,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_data,
    output frame_state_t             frame_state
);

    localparam int IDW = $clog2(N_REQ);
    localparam int DW  = $clog2(CLK_DIV);
    localparam int SW  = $clog2(FRAME_BITS);

    // Frame must hold the W data bits plus the marker slot and result slot.
    if (FRAME_BITS < W + 2) begin : g_bad_frame
        $error("FRAME_BITS must be at least W+2");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (N_REQ < 2) begin : g_bad_nreq
        $error("N_REQ must be at least 2");
    end

    // Handshake: a request is consumed on the clk where req_valid[i] and
    // req_ready[i] are both high; req_ready is a single-clk pulse issued only
    // on the frame-start clk, and operands are sampled on that same edge.

    logic [DW-1:0]   div_q, div_d;
    logic            bclk_q, bclk_d, bclk_fall;
    logic [SW-1:0]   slot_q, slot_d;
    logic            lrclk_q;
    logic            at_f0, at_f2, at_ser;

    frame_state_t    state_q, state_d;
    logic            op_frame;

    logic [N_REQ-1:0] arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    logic [W-1:0]     sel_a, sel_b;
    op_t              sel_op;

    logic [N_REQ-1:0] ready_q;
    logic [W-1:0]     a_sh_q, b_sh_q;
    logic             ser_a_q, ser_b_q;
    logic             minus_a_q, minus_b_q;
    logic [IDW-1:0]   fly_id_q, pend_id_q;
    logic             pend_valid_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [W-1:0]     rsp_data_q;

    // Bit-clock divider and slot counter next state; slot advances on bclk fall.
    always_comb begin
        div_d     = div_q + DW'(1);
        bclk_d    = bclk_q;
        bclk_fall = 1'b0;
        if (div_q == DW'(CLK_DIV - 1)) begin
            div_d     = '0;
            bclk_d    = ~bclk_q;
            bclk_fall = bclk_q;
        end
        slot_d = slot_q;
        if (bclk_fall) begin
            slot_d = (slot_q == SW'(FRAME_BITS - 1)) ? '0 : slot_q + SW'(1);
        end
        at_f0  = bclk_fall && (slot_q == '0);
        at_f2  = bclk_fall && (slot_q == SW'(2));
        at_ser = bclk_fall && (slot_q != '0) && (slot_q <= SW'(W));
    end

    // Timing registers: divider, bclk, slot index, frame marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= '0;
            lrclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            slot_q <= slot_d;
            if (at_f0) begin
                lrclk_q <= ~lrclk_q;
            end
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .advance_i   (at_f0),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Operand/op mux for the current arbitration winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = op_t'(req_op[2*i +: 2]);
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: decided once per frame at frame start.
    always_comb begin
        state_d = state_q;
        if (at_f0) begin
            state_d = arb_any ? OP_FRAME : IDLE_FRAME;
        end
    end

    // Frame FSM outputs.
    always_comb begin
        op_frame    = (state_q == OP_FRAME);
        frame_state = state_q;
    end

    // Operand latch, MSB-first shift-out and per-frame minus controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            ser_a_q   <= 1'b0;
            ser_b_q   <= 1'b0;
            minus_a_q <= 1'b0;
            minus_b_q <= 1'b0;
        end else begin
            ready_q <= at_f0 ? arb_grant : '0;
            if (at_f0) begin
                a_sh_q                 <= arb_any ? sel_a : '0;
                b_sh_q                 <= arb_any ? sel_b : '0;
                ser_a_q                <= 1'b0;
                ser_b_q                <= 1'b0;
                {minus_a_q, minus_b_q} <= arb_any ? op_to_minus(sel_op) : 2'b00;
            end else if (at_ser) begin
                ser_a_q <= a_sh_q[W-1];
                ser_b_q <= b_sh_q[W-1];
                a_sh_q  <= {a_sh_q[W-2:0], 1'b0};
                b_sh_q  <= {b_sh_q[W-2:0], 1'b0};
            end else if (bclk_fall) begin
                ser_a_q <= 1'b0;
                ser_b_q <= 1'b0;
            end
        end
    end

    // Tag pipeline: serializing id moves to pending at frame start; the
    // pending result is returned at slot 2 of the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fly_id_q     <= '0;
            pend_id_q    <= '0;
            pend_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= at_f2 && pend_valid_q;
            if (at_f0) begin
                fly_id_q     <= arb_idx;
                pend_id_q    <= fly_id_q;
                pend_valid_q <= op_frame;
            end else if (at_f2) begin
                pend_valid_q <= 1'b0;
            end
            if (at_f2 && pend_valid_q) begin
                rsp_id_q   <= pend_id_q;
                rsp_data_q <= sum_p;
            end
        end
    end

    assign req_ready = ready_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign ser_a     = ser_a_q;
    assign ser_b     = ser_b_q;
    assign minus_a   = minus_a_q;
    assign minus_b   = minus_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sum_scheduler.sv
// Bench for sum_scheduler with a behavioural bit-serial adder attached.
module tb_sum_scheduler;
    import sum_scheduler_pkg::*;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int CD  = 2;
    localparam int FB  = 10;
    localparam int TPF = FB * 2 * CD;

    logic             clk, rst;
    logic [N-1:0]     req_valid, req_ready;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_a, req_b;
    logic             bclk, lrclk, ser_a, ser_b, minus_a, minus_b;
    logic [W-1:0]     sum_p;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    frame_state_t     frame_state;

    sum_scheduler #(
        .W (W), .N_REQ (N), .CLK_DIV (CD), .FRAME_BITS (FB)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op),
        .req_a (req_a), .req_b (req_b),
        .bclk (bclk), .lrclk (lrclk), .ser_a (ser_a), .ser_b (ser_b),
        .minus_a (minus_a), .minus_b (minus_b), .sum_p (sum_p),
        .rsp_valid (rsp_valid), .rsp_id (rsp_id), .rsp_data (rsp_data),
        .frame_state (frame_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural adder: shifts W bits in on bclk rise after each lrclk edge
    // and presents the previous frame's signed sum once the marker toggles.
    logic [W-1:0] ad_a, ad_b;
    logic         ad_lr, ad_ma, ad_mb;
    int           ad_cnt;

    always @(posedge bclk or posedge rst) begin
        if (rst) begin
            ad_a <= '0; ad_b <= '0; ad_lr <= 1'b0; ad_ma <= 1'b0; ad_mb <= 1'b0;
            ad_cnt <= 0; sum_p <= '0;
        end else if (lrclk != ad_lr) begin
            ad_lr  <= lrclk;
            sum_p  <= (ad_ma ? (W'(0) - ad_a) : ad_a) + (ad_mb ? (W'(0) - ad_b) : ad_b);
            ad_cnt <= 0;
        end else begin
            ad_ma <= minus_a;
            ad_mb <= minus_b;
            if (ad_cnt < W) begin
                ad_a   <= {ad_a[W-2:0], ser_a};
                ad_b   <= {ad_b[W-2:0], ser_b};
                ad_cnt <= ad_cnt + 1;
            end
        end
    end

    // scoreboard / model state
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_id_q[$];
    int           n_tests, n_fail;
    int           e, cur_slot, model_ptr, last_grant, dut_grant, rsp_count;
    logic         lr_exp, due, granted_prev, ma, mb;
    logic [W-1:0] fa, fb, last_rsp;
    logic [1:0]   last_id;

    function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return b - a;
            default: return W'(0) - a - b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clk of observation; the model derives frame timing from the
    // number of clks since reset release.
    task automatic tick();
        logic [N-1:0] exp_ready;
        logic         exp_rsp, exp_sa, exp_sb;
        logic [1:0]   op;
        int           w, c;
        @(negedge clk);
        e++;
        exp_ready  = '0;
        exp_rsp    = 1'b0;
        last_grant = -1;
        dut_grant  = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;
        if (e % (2 * CD) == 0) begin
            cur_slot = (e / (2 * CD) - 1) % FB;
            if (cur_slot == 0) begin
                lr_exp = ~lr_exp;
                due    = granted_prev;
                w      = -1;
                for (int k = 0; k < N; k++) begin
                    c = (model_ptr + k) % N;
                    if (w < 0 && req_valid[c]) w = c;
                end
                granted_prev = (w >= 0);
                if (w >= 0) begin
                    exp_ready[w] = 1'b1;
                    op = req_op[2*w +: 2];
                    fa = req_a[W*w +: W];
                    fb = req_b[W*w +: W];
                    ma = (op == 2'd2) || (op == 2'd3);
                    mb = (op == 2'd1) || (op == 2'd3);
                    exp_q.push_back(ref_result(op, fa, fb));
                    exp_id_q.push_back(2'(w));
                    model_ptr  = (w + 1) % N;
                    last_grant = w;
                end else begin
                    fa = '0; fb = '0; ma = 1'b0; mb = 1'b0;
                end
            end
            if (cur_slot == 2 && due) begin
                exp_rsp = 1'b1;
                due     = 1'b0;
            end
        end
        exp_sa = (cur_slot >= 1 && cur_slot <= W) ? fa[W-cur_slot] : 1'b0;
        exp_sb = (cur_slot >= 1 && cur_slot <= W) ? fb[W-cur_slot] : 1'b0;
        chk("bclk",        32'(bclk),        32'((e / CD) % 2));
        chk("lrclk",       32'(lrclk),       32'(lr_exp));
        chk("req_ready",   32'(req_ready),   32'(exp_ready));
        chk("minus_a",     32'(minus_a),     32'(ma));
        chk("minus_b",     32'(minus_b),     32'(mb));
        chk("ser_a",       32'(ser_a),       32'(exp_sa));
        chk("ser_b",       32'(ser_b),       32'(exp_sb));
        chk("frame_state", 32'(frame_state), 32'(granted_prev));
        chk("rsp_valid",   32'(rsp_valid),   32'(exp_rsp));
        if (rsp_valid) rsp_count++;
        if (exp_rsp && exp_q.size() > 0) begin
            chk("rsp_id",   32'(rsp_id),   32'(exp_id_q.pop_front()));
            chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            last_rsp = rsp_data;
            last_id  = rsp_id;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_bclk",      32'(bclk),      0);
        chk("rst_lrclk",     32'(lrclk),     0);
        chk("rst_ser_a",     32'(ser_a),     0);
        chk("rst_ser_b",     32'(ser_b),     0);
        chk("rst_minus_a",   32'(minus_a),   0);
        chk("rst_minus_b",   32'(minus_b),   0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id",    32'(rsp_id),    0);
        chk("rst_rsp_data",  32'(rsp_data),  0);
        exp_q.delete();
        exp_id_q.delete();
        e = 0; cur_slot = -1; model_ptr = 0; lr_exp = 1'b0; due = 1'b0;
        granted_prev = 1'b0; ma = 1'b0; mb = 1'b0; fa = '0; fb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // driver: raise a request and hold it until the model sees it granted
    task automatic issue(input int id, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        req_op[2*id +: 2] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
        req_valid[id]     = 1'b1;
        for (int t = 0; t < 3 * TPF && !got; t++) begin
            tick();
            if (last_grant == id) got = 1'b1;
        end
        req_valid[id]     = 1'b0;
        req_a[W*id +: W]  = W'($urandom);
        req_b[W*id +: W]  = W'($urandom);
        req_op[2*id +: 2] = 2'($urandom_range(0, 3));
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 3 * TPF && exp_q.size() > 0; t++) tick();
        chk("drain_empty", 32'(exp_q.size()), 0);
        repeat (4) tick();
    endtask

    task automatic wait_slot(input int s);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 2 * TPF && !hit; t++) begin
            tick();
            if (e % (2 * CD) == 0 && cur_slot == s) hit = 1'b1;
        end
        if (!hit) chk("wait_slot_timeout", 0, 1);
    endtask

    int           glog[$];
    int           exp_order[5];
    int           toggles, rsp_before, gi;
    logic         lr_prev;
    logic [1:0]   rop;

    initial begin
        n_tests = 0; n_fail = 0; rsp_count = 0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        last_rsp = '0; last_id = '0;
        do_reset();

        // directed operations
        issue(2, 2'd0, 8'h05, 8'h03); drain();
        chk("add_5_3", 32'(last_rsp), 32'h08);
        chk("add_id",  32'(last_id),  2);
        issue(1, 2'd1, 8'h03, 8'h05); drain();
        chk("sub_ab", 32'(last_rsp), 32'hFE);
        issue(0, 2'd2, 8'h03, 8'h05); drain();
        chk("sub_ba", 32'(last_rsp), 32'h02);
        issue(3, 2'd3, 8'h01, 8'h01); drain();
        chk("neg", 32'(last_rsp), 32'hFE);
        issue(2, 2'd0, 8'hFF, 8'h01); drain();
        chk("wrap", 32'(last_rsp), 32'h00);

        // request withdrawn before frame start must not be granted
        wait_slot(3);
        req_valid[1] = 1'b1;
        tick(); tick();
        req_valid[1] = 1'b0;
        repeat (TPF) tick();

        // idle frames
        rsp_before = rsp_count;
        toggles = 0;
        lr_prev = lrclk;
        for (int t = 0; t < 3 * TPF; t++) begin
            tick();
            if (lrclk !== lr_prev) toggles++;
            lr_prev = lrclk;
        end
        chk("idle_lr_toggles", 32'(toggles), 3);
        chk("idle_no_rsp", 32'(rsp_count - rsp_before), 0);

        // back-to-back random ops
        for (int n = 0; n < 16; n++) begin
            issue($urandom_range(0, N - 1), 2'($urandom_range(0, 3)),
                  W'($urandom), W'($urandom));
        end
        drain();

        // all requesters continuously valid: strict rotation from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'($urandom_range(0, 3));
            req_a[W*i +: W]  = W'($urandom);
            req_b[W*i +: W]  = W'($urandom);
        end
        req_valid = '1;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 3; exp_order[4] = 0;
        for (int g = 0; g < 5; g++) begin
            gi = -1;
            for (int t = 0; t < 2 * TPF && gi < 0; t++) begin
                tick();
                if (last_grant >= 0) begin
                    gi = last_grant;
                    glog.push_back(dut_grant);
                end
            end
            if (gi < 0) begin
                chk("rr_timeout", 0, 1);
            end else begin
                rop = 2'($urandom_range(0, 3));
                req_op[2*gi +: 2] = rop;
                req_a[W*gi +: W]  = W'($urandom);
                req_b[W*gi +: W]  = W'($urandom);
            end
        end
        req_valid = '0;
        drain();
        for (int g = 0; g < glog.size(); g++) chk("rr_order", 32'(glog[g]), 32'(exp_order[g]));
        chk("rr_count", 32'(glog.size()), 5);

        // reset in the middle of a serializing op
        issue(3, 2'd0, 8'h5A, 8'h33);
        wait_slot(W / 2);
        rsp_before = rsp_count;
        do_reset();
        repeat (2 * TPF) tick();
        chk("reset_drop_no_rsp", 32'(rsp_count - rsp_before), 0);
        issue(0, 2'd1, 8'h10, 8'h01); drain();
        chk("post_reset_sub", 32'(last_rsp), 32'h0F);
        chk("post_reset_id",  32'(last_id),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
